// File: rtl/c1_input_loader.sv
// c1_input_loader: streams one image into the replicated C1S2 input buffers, then runs the layer until work_finished.
module c1_input_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 32,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_din,
  output logic              layer_en,
  input  logic              layer_done,
  output logic              frame_done,
  output logic              len_err
);
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic xfer, col_end, last_px;
  assign xfer    = s_valid & s_ready;
  assign col_end = col == CW'(IMG_W - 1);
  assign last_px = col_end && row == RW'(IMG_H - 1);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = (xfer && last_px) ? FLUSH : LOAD;
      FLUSH:   state_n = RUN;
      RUN:     state_n = layer_done ? DONE : RUN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    s_ready    = state == LOAD;
    busy       = state != IDLE;
    frame_done = state == DONE;
  end
  // Write port is registered, so the last pixel lands during FLUSH and layer_en starts one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      row      <= '0;
      col      <= '0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_din  <= '0;
      layer_en <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      buf_we   <= xfer;
      layer_en <= state_n == RUN;
      if (state == IDLE && start) begin
        row     <= '0;
        col     <= '0;
        len_err <= 1'b0;
      end
      if (xfer) begin
        buf_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
        buf_din  <= s_data;
        col      <= col_end ? '0 : col + 1'b1;
        row      <= col_end ? row + 1'b1 : row;
        if (s_last != last_px) len_err <= 1'b1;
      end
    end
  end
endmodule

// File: doc/c1_input_loader.md
Name: c1_input_loader

Overview:
- Upstream feeder for the C1S2 conv/pool layer.
- Accepts one input image as a valid/ready pixel stream and writes it into the five replicated C1S2 input buffers through their shared write port (port b).
- After the last pixel's write has landed, holds the layer enable until the layer reports `work_finished`, then pulses frame-done.
- One image per `start`; sequences load and compute so they never overlap.

Parameters:
- DATA_W, 16, pixel width (matches buffer din).
- ADDR_W, 32, buffer address width (matches buffer write address bus).
- IMG_W, 32, pixels per row.
- IMG_H, 32, rows per image.
- BASE_ADDR, 0, buffer word address of pixel (0,0).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin loading one frame; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- s_valid  in  1  pixel valid.
- s_data  in  DATA_W  pixel value.
- s_last  in  1  marks final pixel of frame.
- s_ready  out  1  loader can accept pixel.
- buf_we  out  1  write enable to all five buffers (port b web).
- buf_addr  out  ADDR_W  write address (port b addrb).
- buf_din  out  DATA_W  write data (port b dinb).
- layer_en  out  1  enable to C1S2 layer.
- layer_done  in  1  `work_finished` from C1S2 layer.
- frame_done  out  1  one-cycle pulse when frame fully processed.
- len_err  out  1  sticky: `s_last` disagreed with pixel count.

Behaviour:
- Reset: all outputs 0; state IDLE; row/col counters 0; len_err cleared.
- States: IDLE, LOAD, FLUSH, RUN, DONE.
- IDLE:
  - s_ready=0.
  - start=1 -> LOAD; row=col=0.
  - start=1 clears len_err.
- LOAD:
  - s_ready=1, combinational from state only; must not depend on s_valid.
  - A transfer occurs on s_valid & s_ready.
  - On a transfer, the next cycle presents buf_we=1, buf_addr=BASE_ADDR+row*IMG_W+col, buf_din=s_data. The write is registered, 1-cycle latency.
  - No transfer: buf_we=0 next cycle; addr/din hold their last value.
  - col increments; at col==IMG_W-1 it wraps to 0 and row increments.
  - Transfer of pixel (IMG_H-1, IMG_W-1) -> FLUSH; s_ready drops the same cycle.
  - s_last=1 on any other transfer -> len_err=1; loading continues and the pixel is still written.
  - Final pixel transferred with s_last=0 -> len_err=1.
- FLUSH:
  - One cycle; the final write is on the bus (buf_we=1).
  - -> RUN.
- RUN:
  - layer_en=1, registered; first asserted the cycle after FLUSH, so the buffer already holds the final pixel.
  - s_ready=0.
  - layer_done=1 -> DONE; layer_en deasserts next cycle.
- DONE:
  - frame_done=1 for exactly one cycle.
  - -> IDLE; busy falls the cycle after.
- Boundaries:
  - layer_done outside RUN: ignored.
  - layer_done high on first RUN cycle: legal; RUN lasts one cycle.
  - start outside IDLE: ignored, no queuing.
  - start and rst same cycle: reset wins.
  - rst mid-LOAD or mid-RUN: layer_en and buf_we low next cycle; partially written buffer contents are not cleared.
  - s_valid held with no transfer outside LOAD: no effect.
  - Address arithmetic in ADDR_W bits: row*IMG_W zero-extended, no overflow checks.
  - Total frame pixels = IMG_W*IMG_H; counters sized ceil(log2) of each dimension, minimum 1 bit.
- Throughput:
  - One pixel per cycle with s_valid held.
  - Frame load = IMG_W*IMG_H cycles.
  - start-to-first-layer_en = IMG_W*IMG_H+2 cycles.

Test Plan:
- Reset, start, then 1024 pixels back-to-back with s_data=10000+i and s_last on i=1023:
  - buf_we high 1024 consecutive cycles.
  - buf_addr 0..1023, buf_din 10000..11023.
  - layer_en rises at cycle 1026 after start.
  - len_err=0.
- Same frame with s_valid toggled by random 50% pattern:
  - addresses contiguous, no duplicates or skips.
  - buf_we count=1024.
  - written data matches stream order.
- layer_done held low 500 cycles after RUN entry, then pulsed:
  - layer_en high exactly 501 cycles.
  - frame_done single pulse the cycle after layer_en falls.
  - busy low next cycle.
- s_last on pixel 511 and absent on pixel 1023:
  - len_err=1.
  - all 1024 pixels still written.
  - next start clears len_err.
- start pulsed during LOAD and during RUN:
  - no effect; addresses continue uninterrupted.
  - exactly one frame_done.
- rst asserted at pixel 300:
  - next cycle all outputs 0, state IDLE.
  - new start reloads from BASE_ADDR; with BASE_ADDR=2048, first buf_addr=2048, last 3071.
